// File: rtl/vfx_stream_pkg.sv
// vfx_stream_pkg: shared pixel-stream types for the video filter chain
package vfx_stream_pkg;
  localparam int PIXEL_BITS = 12;
  typedef logic [PIXEL_BITS-1:0] rgb444_t;
  typedef struct packed {
    logic    sop;
    logic    eop;
    rgb444_t data;
  } st_beat_t;
  typedef enum logic [2:0] {IDLE, STREAM, PAD, FLUSH, DRAIN} regulator_state_t;
endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry beat buffer decoupling a push source from a ready/valid sink
module stream_skid_buffer
  import vfx_stream_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_push,
  input  st_beat_t i_beat,
  output logic     o_full,
  output logic     o_valid,
  input  logic     i_ready,
  output st_beat_t o_beat
);
  st_beat_t   r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_cnt;
  logic       w_pop;
  assign o_valid = r_cnt != 2'd0;
  assign o_full  = r_cnt == 2'd2;
  assign o_beat  = r_mem[r_rd];
  assign w_pop   = o_valid && i_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= '{default: '0};
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_beat;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/frame_packet_regulator.sv
// frame_packet_regulator: re-emits exactly IMAGE_WIDTH*IMAGE_HEIGHT-pixel frames,
// padding short frames, truncating long ones and dropping pre-SOP beats
module frame_packet_regulator
  import vfx_stream_pkg::*;
#(
  parameter int      IMAGE_WIDTH  = 320,
  parameter int      IMAGE_HEIGHT = 240,
  parameter rgb444_t PAD_COLOUR   = 12'h000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid_in,
  input  logic          startofpacket_in,
  input  logic          endofpacket_in,
  input  logic [11:0]   data_in,
  output logic          ready_out,
  input  logic          ready_in,
  output logic          valid_out,
  output logic          startofpacket_out,
  output logic          endofpacket_out,
  output logic [11:0]   data_out,
  output logic [31:0]   pixel_count_out,
  output logic [15:0]   short_frame_count,
  output logic [15:0]   long_frame_count
);
  localparam int          TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [31:0] LAST_IDX     = 32'(TOTAL_PIXELS - 1);
  regulator_state_t r_state, w_next;
  logic [31:0] r_count;
  logic        r_pend_v, r_pend_eop;
  rgb444_t     r_pend_data;
  logic [15:0] r_short, r_long;
  logic        w_full, w_accept, w_push, w_last, w_short_inc, w_long_inc;
  st_beat_t    w_beat, w_out;
  assign w_last    = r_count == LAST_IDX;
  assign ready_out = reset_n && !w_full && (r_state inside {IDLE, STREAM, DRAIN});
  assign w_accept  = valid_in && ready_out;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DRAIN: if (w_accept && startofpacket_in) w_next = endofpacket_in ? PAD : STREAM;
      STREAM: if (w_accept) w_next = startofpacket_in ? PAD :
                                     w_last ? (endofpacket_in ? IDLE : DRAIN) :
                                     endofpacket_in ? PAD : STREAM;
      PAD:    if (!w_full && w_last) w_next = r_pend_v ? FLUSH : IDLE;
      FLUSH:  if (!w_full) w_next = r_pend_eop ? PAD : STREAM;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_push      = 1'b0;
    w_beat      = '{sop: 1'b0, eop: 1'b0, data: data_in};
    w_short_inc = 1'b0;
    w_long_inc  = 1'b0;
    case (r_state)
      IDLE, DRAIN: begin
        w_push      = w_accept && startofpacket_in;
        w_beat.sop  = 1'b1;
        w_short_inc = w_push && endofpacket_in;
      end
      STREAM: begin
        w_push      = w_accept && !startofpacket_in;
        w_beat.eop  = w_last;
        w_short_inc = w_accept && (startofpacket_in || (!w_last && endofpacket_in));
        w_long_inc  = w_push && w_last && !endofpacket_in;
      end
      PAD: begin
        w_push = !w_full;
        w_beat = '{sop: 1'b0, eop: w_last, data: PAD_COLOUR};
      end
      FLUSH: begin
        w_push      = !w_full;
        w_beat      = '{sop: 1'b1, eop: 1'b0, data: r_pend_data};
        w_short_inc = w_push && r_pend_eop;
      end
      default: ;
    endcase
  end
  // an early SOP is parked here while the interrupted frame is padded out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_pend_v    <= 1'b0;
      r_pend_eop  <= 1'b0;
      r_pend_data <= '0;
      r_short     <= '0;
      r_long      <= '0;
    end else begin
      if (w_push) r_count <= w_beat.eop ? 32'd0 : w_beat.sop ? 32'd1 : r_count + 32'd1;
      if (r_state == STREAM && w_accept && startofpacket_in) begin
        r_pend_v    <= 1'b1;
        r_pend_eop  <= endofpacket_in;
        r_pend_data <= data_in;
      end else if (r_state == FLUSH && w_push) begin
        r_pend_v <= 1'b0;
      end
      if (w_short_inc && r_short != 16'hFFFF) r_short <= r_short + 16'd1;
      if (w_long_inc && r_long != 16'hFFFF) r_long <= r_long + 16'd1;
    end
  end
  stream_skid_buffer u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_beat  (w_beat),
    .o_full  (w_full),
    .o_valid (valid_out),
    .i_ready (ready_in),
    .o_beat  (w_out)
  );
  assign startofpacket_out = w_out.sop;
  assign endofpacket_out   = w_out.eop;
  assign data_out          = w_out.data;
  assign pixel_count_out   = r_count;
  assign short_frame_count = r_short;
  assign long_frame_count  = r_long;
endmodule
